// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: captures MIDI note events and assigns them to voices
// using a one-voice-per-cycle scan, with oldest-voice stealing when the bank is full.
module voice_allocator #(
  parameter int NUM_VOICES   = 4,
  parameter int MIDI_CHANNEL = 0,
  parameter bit OMNI         = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    midi_byte_ready,
  input  logic [7:0]              midi_byte0,
  input  logic [7:0]              midi_byte1,
  input  logic [7:0]              midi_byte2,
  output logic [NUM_VOICES-1:0]   voice_active,
  output logic [7*NUM_VOICES-1:0] voice_note,
  output logic [7*NUM_VOICES-1:0] voice_velocity,
  output logic [NUM_VOICES-1:0]   voice_trigger,
  output logic                    busy,
  output logic                    event_dropped
);
  localparam int IW = $clog2(NUM_VOICES);
  localparam logic [IW-1:0] LAST = IW'(NUM_VOICES - 1);

  typedef enum logic [1:0] {K_NONE, K_ON, K_OFF, K_ALL} kind_e;
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} state_e;
  typedef struct packed {
    kind_e      kind;
    logic [6:0] note;
    logic [6:0] vel;
  } evt_t;

  state_e                        r_state;
  logic                          r_rdy_q;
  evt_t                          r_work, r_pend;
  logic                          r_pend_vld;
  logic [IW-1:0]                 r_idx, r_match, r_free, r_old;
  logic                          r_match_v, r_free_v, r_old_v;
  logic [NUM_VOICES-1:0][6:0]    r_note, r_vel;
  logic [NUM_VOICES-1:0][IW-1:0] r_rank;

  evt_t          w_in, w_ld_evt;
  logic          w_edge, w_chan_ok, w_evt, w_ld, w_pend_wr, w_tgt_v;
  logic [IW-1:0] w_tgt;

  always_comb begin
    w_in.kind = K_NONE;
    w_in.note = midi_byte1[6:0];
    w_in.vel  = midi_byte2[6:0];
    case (midi_byte0[7:4])
      4'h8:    w_in.kind = K_OFF;
      4'h9:    w_in.kind = (midi_byte2 != 8'd0) ? K_ON : K_OFF;
      4'hB:    w_in.kind = (midi_byte1 == 8'd123) ? K_ALL : K_NONE;
      default: w_in.kind = K_NONE;
    endcase
  end

  assign w_chan_ok = OMNI || (midi_byte0[3:0] == 4'(MIDI_CHANNEL));
  assign w_edge    = midi_byte_ready && !r_rdy_q;
  assign w_evt     = w_edge && w_chan_ok && (w_in.kind != K_NONE);
  // A new event can start in IDLE or straight out of COMMIT; pending goes first.
  assign w_ld      = ((r_state == S_IDLE) || (r_state == S_COMMIT)) && (r_pend_vld || w_evt);
  assign w_ld_evt  = r_pend_vld ? r_pend : w_in;
  assign w_pend_wr = w_evt && !(w_ld && !r_pend_vld);
  assign w_tgt_v   = r_match_v || r_free_v || r_old_v;
  assign w_tgt     = r_match_v ? r_match : (r_free_v ? r_free : r_old);

  assign busy           = (r_state != S_IDLE);
  assign voice_note     = r_note;
  assign voice_velocity = r_vel;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_rdy_q       <= 1'b0;
      r_work        <= '0;
      r_pend        <= '0;
      r_pend_vld    <= 1'b0;
      r_idx         <= '0;
      r_match       <= '0;
      r_free        <= '0;
      r_old         <= '0;
      r_match_v     <= 1'b0;
      r_free_v      <= 1'b0;
      r_old_v       <= 1'b0;
      r_note        <= '0;
      r_vel         <= '0;
      voice_active  <= '0;
      voice_trigger <= '0;
      event_dropped <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) r_rank[i] <= IW'(i);
    end else begin
      r_rdy_q       <= midi_byte_ready;
      voice_trigger <= '0;
      event_dropped <= 1'b0;

      if (w_pend_wr) begin
        r_pend        <= w_in;
        r_pend_vld    <= 1'b1;
        event_dropped <= r_pend_vld && !w_ld;
      end else if (w_ld && r_pend_vld) begin
        r_pend_vld <= 1'b0;
      end

      case (r_state)
        S_SCAN: begin
          if (voice_active[r_idx] && (r_note[r_idx] == r_work.note) && !r_match_v) begin
            r_match_v <= 1'b1;
            r_match   <= r_idx;
          end
          if (!voice_active[r_idx] && !r_free_v) begin
            r_free_v <= 1'b1;
            r_free   <= r_idx;
          end
          if (r_rank[r_idx] == LAST) begin
            r_old_v <= 1'b1;
            r_old   <= r_idx;
          end
          r_idx <= r_idx + 1'b1;
          if (r_idx == LAST) r_state <= S_COMMIT;
        end
        S_COMMIT: begin
          case (r_work.kind)
            K_ON: if (w_tgt_v) begin
              voice_active[w_tgt]  <= 1'b1;
              r_note[w_tgt]        <= r_work.note;
              r_vel[w_tgt]         <= r_work.vel;
              voice_trigger[w_tgt] <= 1'b1;
              // Age every voice newer than the target, target becomes newest.
              for (int j = 0; j < NUM_VOICES; j++)
                if (r_rank[j] < r_rank[w_tgt]) r_rank[j] <= r_rank[j] + 1'b1;
              r_rank[w_tgt] <= '0;
            end
            K_OFF:   if (r_match_v) voice_active[r_match] <= 1'b0;
            K_ALL:   voice_active <= '0;
            default: ;
          endcase
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_ld) begin
        r_work    <= w_ld_evt;
        r_idx     <= '0;
        r_match_v <= 1'b0;
        r_free_v  <= 1'b0;
        r_old_v   <= 1'b0;
        r_state   <= (w_ld_evt.kind == K_ALL) ? S_COMMIT : S_SCAN;
      end
    end
  end
endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: one task per scenario with inline checks.
module tb_voice_allocator;
  localparam int NV = 4;

  logic clk = 1'b0, reset = 1'b1, rdy = 1'b0;
  logic [7:0] b0 = 8'h00, b1 = 8'h00, b2 = 8'h00;
  logic [NV-1:0] act, trig, c_act, c_trig;
  logic [7*NV-1:0] note, vel, c_note, c_vel;
  logic busy, drop, c_busy, c_drop;
  int errors = 0, checks = 0;
  int trig_cnt = 0, drop_cnt = 0, cbusy_cnt = 0;

  always #5 clk = ~clk;

  voice_allocator #(.NUM_VOICES(NV), .MIDI_CHANNEL(0), .OMNI(1'b1)) dut (
    .clk(clk), .reset(reset), .midi_byte_ready(rdy),
    .midi_byte0(b0), .midi_byte1(b1), .midi_byte2(b2),
    .voice_active(act), .voice_note(note), .voice_velocity(vel),
    .voice_trigger(trig), .busy(busy), .event_dropped(drop));

  voice_allocator #(.NUM_VOICES(NV), .MIDI_CHANNEL(2), .OMNI(1'b0)) dut_ch (
    .clk(clk), .reset(reset), .midi_byte_ready(rdy),
    .midi_byte0(b0), .midi_byte1(b1), .midi_byte2(b2),
    .voice_active(c_act), .voice_note(c_note), .voice_velocity(c_vel),
    .voice_trigger(c_trig), .busy(c_busy), .event_dropped(c_drop));

  always @(negedge clk) begin
    if (trig != '0) trig_cnt++;
    if (drop) drop_cnt++;
    if (c_busy) cbusy_cnt++;
  end

  function automatic logic [6:0] nt(input int i);
    return note[7*i +: 7];
  endfunction

  function automatic logic [6:0] vl(input int i);
    return vel[7*i +: 7];
  endfunction

  task automatic do_reset();
    reset = 1'b1; rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Deliver one message and return at the cycle its result becomes visible.
  task automatic play(input logic [7:0] s, input logic [7:0] d1, input logic [7:0] d2);
    b0 = s; b1 = d1; b2 = d2; rdy = 1'b1;
    @(posedge clk); #1 rdy = 1'b0;
    repeat (NV + 1) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (act !== 4'b0000) begin errors++; $display("FAIL reset_active: got %b exp 0000", act); end
    checks++; if (note !== '0 || vel !== '0) begin errors++; $display("FAIL reset_note_vel: got %h/%h exp 0/0", note, vel); end
    checks++; if (trig !== 4'b0000 || busy !== 1'b0 || drop !== 1'b0) begin errors++; $display("FAIL reset_ctl: got trig=%b busy=%b drop=%b exp 0", trig, busy, drop); end
  endtask

  task automatic test_note_on_off();
    int base;
    base = trig_cnt;
    b0 = 8'h90; b1 = 8'd60; b2 = 8'd100; rdy = 1'b1;
    @(posedge clk); #1 rdy = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL on_busy_c1: got %b exp 1", busy); end
    repeat (NV) @(posedge clk); #1;
    checks++; if (act !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL on_commit_c5: got act=%b busy=%b exp 0000/1", act, busy); end
    @(posedge clk); #1;
    checks++; if (act !== 4'b0001 || trig !== 4'b0001 || busy !== 1'b0) begin errors++; $display("FAIL on_c6: got act=%b trig=%b busy=%b exp 0001/0001/0", act, trig, busy); end
    checks++; if (nt(0) !== 7'd60 || vl(0) !== 7'd100) begin errors++; $display("FAIL on_note_vel: got %0d/%0d exp 60/100", nt(0), vl(0)); end
    play(8'h80, 8'd60, 8'd0);
    @(posedge clk); #1;
    checks++; if (act !== 4'b0000 || nt(0) !== 7'd60) begin errors++; $display("FAIL off: got act=%b note=%0d exp 0000/60", act, nt(0)); end
    checks++; if (trig_cnt - base !== 1) begin errors++; $display("FAIL off_trig_count: got %0d exp 1", trig_cnt - base); end
  endtask

  task automatic test_retrigger();
    int base;
    do_reset();
    base = trig_cnt;
    play(8'h90, 8'd60, 8'd100);
    play(8'h90, 8'd60, 8'd40);
    checks++; if (trig !== 4'b0001) begin errors++; $display("FAIL retrig_pulse: got %b exp 0001", trig); end
    @(posedge clk); #1;
    checks++; if (act !== 4'b0001 || vl(0) !== 7'd40) begin errors++; $display("FAIL retrig_state: got act=%b vel=%0d exp 0001/40", act, vl(0)); end
    checks++; if (trig_cnt - base !== 2) begin errors++; $display("FAIL retrig_count: got %0d exp 2", trig_cnt - base); end
    play(8'h90, 8'd60, 8'd0);
    checks++; if (act !== 4'b0000 || trig !== 4'b0000) begin errors++; $display("FAIL vel0_off: got act=%b trig=%b exp 0000/0000", act, trig); end
  endtask

  task automatic test_fill_steal();
    do_reset();
    play(8'h90, 8'd60, 8'd100);
    play(8'h90, 8'd62, 8'd100);
    play(8'h90, 8'd64, 8'd100);
    play(8'h90, 8'd67, 8'd100);
    checks++; if (act !== 4'b1111 || note !== {7'd67, 7'd64, 7'd62, 7'd60}) begin errors++; $display("FAIL fill: got act=%b note=%h exp 1111 67/64/62/60", act, note); end
    play(8'h90, 8'd71, 8'd90);
    checks++; if (trig !== 4'b0001 || nt(0) !== 7'd71) begin errors++; $display("FAIL steal_v0: got trig=%b note=%0d exp 0001/71", trig, nt(0)); end
    play(8'h90, 8'd72, 8'd90);
    checks++; if (trig !== 4'b0010) begin errors++; $display("FAIL steal_v1: got trig=%b exp 0010", trig); end
    play(8'h90, 8'd74, 8'd90);
    checks++; if (trig !== 4'b0100) begin errors++; $display("FAIL steal_v2: got trig=%b exp 0100", trig); end
    play(8'h90, 8'd76, 8'd90);
    checks++; if (trig !== 4'b1000 || note !== {7'd76, 7'd74, 7'd72, 7'd71}) begin errors++; $display("FAIL steal_v3: got trig=%b note=%h exp 1000 76/74/72/71", trig, note); end
  endtask

  task automatic test_channel();
    int base;
    do_reset();
    base = cbusy_cnt;
    play(8'h93, 8'd50, 8'd90);
    checks++; if (cbusy_cnt - base !== 0 || c_act !== 4'b0000) begin errors++; $display("FAIL chan_ignore: got busycycles=%0d act=%b exp 0/0000", cbusy_cnt - base, c_act); end
    play(8'h92, 8'd50, 8'd90);
    checks++; if (c_act !== 4'b0001 || c_note[6:0] !== 7'd50 || c_trig !== 4'b0001) begin errors++; $display("FAIL chan_accept: got act=%b note=%0d trig=%b exp 0001/50/0001", c_act, c_note[6:0], c_trig); end
  endtask

  task automatic test_all_off();
    do_reset();
    play(8'h90, 8'd60, 8'd100);
    play(8'h90, 8'd62, 8'd100);
    play(8'h90, 8'd64, 8'd100);
    checks++; if (act !== 4'b0111) begin errors++; $display("FAIL alloff_pre: got %b exp 0111", act); end
    b0 = 8'hB0; b1 = 8'd123; b2 = 8'd0; rdy = 1'b1;
    @(posedge clk); #1 rdy = 1'b0;
    checks++; if (busy !== 1'b1 || act !== 4'b0111) begin errors++; $display("FAIL alloff_c1: got busy=%b act=%b exp 1/0111", busy, act); end
    @(posedge clk); #1;
    checks++; if (act !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL alloff_c2: got act=%b busy=%b exp 0000/0", act, busy); end
  endtask

  task automatic test_back_to_back();
    int bd, bt;
    do_reset();
    bd = drop_cnt; bt = trig_cnt;
    b0 = 8'h90; b1 = 8'd60; b2 = 8'd100; rdy = 1'b1;
    @(posedge clk); #1 rdy = 1'b0;
    @(posedge clk); #1 b1 = 8'd62; rdy = 1'b1;
    @(posedge clk); #1 rdy = 1'b0;
    @(posedge clk); #1 b1 = 8'd64; rdy = 1'b1;
    @(posedge clk); #1 rdy = 1'b0;
    checks++; if (drop !== 1'b1) begin errors++; $display("FAIL b2b_drop_pulse: got %b exp 1", drop); end
    @(posedge clk); #1;
    checks++; if (act !== 4'b0001 || trig !== 4'b0001 || busy !== 1'b1) begin errors++; $display("FAIL b2b_first: got act=%b trig=%b busy=%b exp 0001/0001/1", act, trig, busy); end
    repeat (5) @(posedge clk); #1;
    checks++; if (act !== 4'b0011 || nt(1) !== 7'd64 || trig !== 4'b0010 || busy !== 1'b0) begin errors++; $display("FAIL b2b_third: got act=%b note1=%0d trig=%b busy=%b exp 0011/64/0010/0", act, nt(1), trig, busy); end
    @(posedge clk); #1;
    checks++; if (drop_cnt - bd !== 1 || trig_cnt - bt !== 2) begin errors++; $display("FAIL b2b_counts: got drops=%0d trigs=%0d exp 1/2", drop_cnt - bd, trig_cnt - bt); end
  endtask

  task automatic test_held_high();
    int base;
    do_reset();
    base = trig_cnt;
    b0 = 8'h90; b1 = 8'd60; b2 = 8'd100; rdy = 1'b1;
    repeat (8) @(posedge clk);
    #1 b1 = 8'd62;
    repeat (12) @(posedge clk);
    #1 rdy = 1'b0;
    @(posedge clk); #1;
    checks++; if (act !== 4'b0001 || trig_cnt - base !== 1) begin errors++; $display("FAIL held_high: got act=%b trigs=%0d exp 0001/1", act, trig_cnt - base); end
  endtask

  task automatic test_reset_mid_scan();
    int base;
    do_reset();
    base = trig_cnt;
    b0 = 8'h90; b1 = 8'd60; b2 = 8'd100; rdy = 1'b1;
    @(posedge clk); #1 rdy = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    checks++; if (act !== 4'b0000 || busy !== 1'b0 || trig !== 4'b0000) begin errors++; $display("FAIL midscan_reset: got act=%b busy=%b trig=%b exp 0", act, busy, trig); end
    repeat (8) @(posedge clk); #1;
    checks++; if (trig_cnt - base !== 0 || act !== 4'b0000) begin errors++; $display("FAIL midscan_no_alloc: got trigs=%0d act=%b exp 0/0000", trig_cnt - base, act); end
    play(8'h90, 8'd62, 8'd80);
    checks++; if (trig !== 4'b0001 || nt(0) !== 7'd62 || act !== 4'b0001) begin errors++; $display("FAIL midscan_next: got trig=%b note=%0d act=%b exp 0001/62/0001", trig, nt(0), act); end
  endtask

  initial begin
    test_reset();
    test_note_on_off();
    test_retrigger();
    test_fill_steal();
    test_channel();
    test_all_off();
    test_back_to_back();
    test_held_high();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
